// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - nibble-serial add/subtract sequencer around one fourbitadder slice
module fourbitadder (
    input  logic [3:0] addent,
    input  logic [3:0] augend,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    assign {cout, s} = {1'b0, addent} + {1'b0, augend} + {4'b0000, cin};
endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    input  logic                   sub,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   ovf
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic [W-1:0]  sum_sr;
    logic [W-1:0]  sum_next;
    logic [W-1:0]  slice_ext;
    logic [W-1:0]  b_eff;
    logic [CW-1:0] cnt;
    logic          carry;
    logic          a_msb;
    logic          b_msb;
    logic          accept;
    logic          last_nibble;
    logic [3:0]    slice_s;
    logic          slice_cout;

    assign busy        = (state == RUN);
    assign done        = (state == DONE);
    assign accept      = start && (state != RUN);
    assign last_nibble = (state == RUN) && (cnt == LAST);
    assign b_eff       = sub ? ~b : b;

    // Each slice result enters at the top so the LS nibble ends up at the bottom.
    assign slice_ext = W'(slice_s);
    assign sum_next  = (sum_sr >> 4) | (slice_ext << (W - 4));

    fourbitadder u_slice (
        .addent (a_sr[3:0]),
        .augend (b_sr[3:0]),
        .cin    (carry),
        .s      (slice_s),
        .cout   (slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state <= RUN;
                RUN:     if (cnt == LAST) state <= DONE;
                DONE:    state <= start ? RUN : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b_eff;
            carry <= sub | cin;
            cnt   <= '0;
            a_msb <= a[W-1];
            b_msb <= b_eff[W-1];
        end else if (state == RUN) begin
            sum_sr <= sum_next;
            a_sr   <= a_sr >> 4;
            b_sr   <= b_sr >> 4;
            carry  <= slice_cout;
            cnt    <= cnt + CW'(1);
        end
    end

    // Visible results update only on the final nibble so they stay stable while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (last_nibble) begin
            sum  <= sum_next;
            cout <= slice_cout;
            ovf  <= (a_msb == b_msb) && (slice_s[3] != a_msb);
        end
    end
endmodule
